// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample vote, parity/stop/break checks and a valid/ready holding register
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int OVERSAMPLE = 16,
  localparam int SAMPLE_COUNTER_WIDTH = $clog2(OVERSAMPLE)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       baud_en_i,
  input  logic                       rx_en_i,
  input  logic                       uart_rx_i,
  input  logic [4:0]                 rx_conf_i,
  input  logic                       rx_ready_i,
  output logic                       rx_valid_o,
  output logic [MAX_UART_DATA_W-1:0] rx_data_o,
  output logic                       rx_parity_err_o,
  output logic                       rx_frame_err_o,
  output logic                       rx_break_o,
  output logic                       rx_overrun_o,
  output logic                       rx_busy_o
);
  localparam int BW = $clog2(MAX_UART_DATA_W);
  localparam int M = OVERSAMPLE / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic [1:0] samp_q;
  logic [SAMPLE_COUNTER_WIDTH-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [4:0] conf_q;
  logic [MAX_UART_DATA_W-1:0] sh_q;
  logic par_q, pe_q, fe_q, stop2_q;
  logic rx_s, vote, mid, last, last_bit, final_stop, done, fe_new, brk_new;
  assign rx_s = sync_q[1];
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign mid = cnt_q == SAMPLE_COUNTER_WIDTH'(M + 1);
  assign last = cnt_q == SAMPLE_COUNTER_WIDTH'(OVERSAMPLE - 1);
  assign last_bit = bit_q == BW'(conf_q[4:3]) + BW'(4);
  assign final_stop = !conf_q[2] || stop2_q;
  assign done = baud_en_i && rx_en_i && state_q == STOP && mid && final_stop;
  assign fe_new = fe_q | ~vote;
  assign brk_new = ~|sh_q & ~(conf_q[0] & par_q) & ~vote;
  assign rx_busy_o = state_q != IDLE;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], uart_rx_i};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      samp_q <= 2'b11;
      bit_q <= '0;
      conf_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      stop2_q <= 1'b0;
    end else if (baud_en_i) begin
      if (!rx_en_i) state_q <= IDLE;
      else begin
        if (cnt_q == SAMPLE_COUNTER_WIDTH'(M - 1) || cnt_q == SAMPLE_COUNTER_WIDTH'(M)) samp_q <= {samp_q[0], rx_s};
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        case (state_q)
          IDLE: if (!rx_s) begin
            state_q <= START;
            cnt_q <= '0;
            conf_q <= rx_conf_i;
            sh_q <= '0;
            bit_q <= '0;
            par_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= 1'b0;
            stop2_q <= 1'b0;
          end
          START: state_q <= (mid && vote) ? IDLE : last ? DATA : START;
          DATA: begin
            if (mid) sh_q[bit_q] <= vote;
            if (last) begin
              bit_q <= bit_q + 1'b1;
              if (last_bit) state_q <= conf_q[0] ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (mid) begin
              par_q <= vote;
              pe_q <= (^sh_q ^ vote) != conf_q[1];
            end
            if (last) state_q <= STOP;
          end
          STOP: begin
            if (mid) begin
              fe_q <= fe_new;
              if (final_stop) state_q <= brk_new ? BREAK_WAIT : IDLE;
            end
            if (last) stop2_q <= 1'b1;
          end
          BREAK_WAIT: if (rx_s) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_o <= 1'b0;
      rx_data_o <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_break_o <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_overrun_o <= done && rx_valid_o && !rx_ready_i;
      if (done && (!rx_valid_o || rx_ready_i)) begin
        rx_valid_o <= 1'b1;
        rx_data_o <= sh_q;
        rx_parity_err_o <= pe_q;
        rx_frame_err_o <= fe_new;
        rx_break_o <= brk_new;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
        rx_parity_err_o <= 1'b0;
        rx_frame_err_o <= 1'b0;
        rx_break_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: table-driven and directed checks of uart_rx_os
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int OS = 16;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic baud_en_i = 1'b0;
  logic rx_en_i = 1'b1;
  logic uart_rx_i = 1'b1;
  logic [4:0] rx_conf_i = 5'b11000;
  logic rx_ready_i = 1'b0;
  logic rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o, rx_busy_o;
  logic [7:0] rx_data_o;
  typedef struct {logic [7:0] d; logic pe; logic fe; logic brk;} word_t;
  typedef struct {logic [4:0] conf; logic [7:0] d; logic p; logic [1:0] stp; logic [7:0] ed; logic epe; logic efe; logic ebrk;} vec_t;
  word_t q[$];
  vec_t vt[11];
  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int o0;
  always #5 clk = ~clk;
  uart_rx_os #(.MAX_UART_DATA_W(8), .OVERSAMPLE(OS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .baud_en_i(baud_en_i), .rx_en_i(rx_en_i),
    .uart_rx_i(uart_rx_i), .rx_conf_i(rx_conf_i), .rx_ready_i(rx_ready_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .rx_break_o(rx_break_o), .rx_overrun_o(rx_overrun_o),
    .rx_busy_o(rx_busy_o)
  );
  always @(negedge clk) begin
    if (rx_valid_o && rx_ready_i) q.push_back('{rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_break_o});
    if (rx_overrun_o) ovr_cnt++;
  end
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask
  task automatic expect_word(input string n, input logic [7:0] d, input int pe, input logic fe, input logic brk);
    word_t w;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no word received, expected data 0x%0h", n, d);
    end else begin
      w = q.pop_front();
      chk({n, " data"}, 32'(w.d), 32'(d));
      if (pe >= 0) chk({n, " parity_err"}, 32'(w.pe), 32'(pe));
      chk({n, " frame_err"}, 32'(w.fe), 32'(fe));
      chk({n, " break"}, 32'(w.brk), 32'(brk));
    end
  endtask
  task automatic tick(input bit acc = 1'b0);
    logic r;
    r = rx_ready_i;
    if (acc) rx_ready_i = 1'b1;
    baud_en_i = 1'b1;
    @(posedge clk);
    #1 baud_en_i = 1'b0;
    rx_ready_i = r;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    uart_rx_i = 1'b1;
    repeat (n) tick();
  endtask
  task automatic send(input logic [4:0] conf, input logic [7:0] d, input logic p, input logic [1:0] stp,
                      input int acc_t = -1, input int flip_t = -1, input int off_t = -1);
    logic [12:0] bits;
    int w;
    int n;
    int k;
    w = 5 + int'(conf[4:3]);
    rx_conf_i = conf;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < w; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (conf[0]) begin
      bits[n] = p;
      n++;
    end
    bits[n] = stp[0];
    n++;
    if (conf[2]) begin
      bits[n] = stp[1];
      n++;
    end
    for (int b = 0; b < n; b++)
      for (int t = 0; t < OS; t++) begin
        k = b * OS + t;
        uart_rx_i = bits[b] ^ (k == flip_t);
        if (k == off_t) rx_en_i = 1'b0;
        tick(k == acc_t);
      end
    uart_rx_i = 1'b1;
  endtask
  initial begin
    vt[0]  = '{5'b11000, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{5'b10101, 8'h35, 1'b1, 2'b11, 8'h35, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{5'b10101, 8'h35, 1'b0, 2'b11, 8'h35, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{5'b10101, 8'h35, 1'b0, 2'b01, 8'h35, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{5'b10101, 8'h35, 1'b0, 2'b10, 8'h35, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{5'b00011, 8'h1F, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{5'b00011, 8'h1F, 1'b1, 2'b11, 8'h1F, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{5'b00000, 8'hFF, 1'b0, 2'b01, 8'h1F, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{5'b01000, 8'h2A, 1'b0, 2'b01, 8'h2A, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{5'b11011, 8'h00, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[10] = '{5'b11001, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(rx_valid_o), 0);
    chk("reset data", 32'(rx_data_o), 0);
    chk("reset flags", 32'({rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o}), 0);
    chk("reset busy", 32'(rx_busy_o), 0);
    rst_ni = 1'b1;
    rx_ready_i = 1'b1;
    idle(4);
    for (int i = 0; i < 11; i++) begin
      send(vt[i].conf, vt[i].d, vt[i].p, vt[i].stp);
      idle(8);
      expect_word($sformatf("vec%0d", i), vt[i].ed, int'(vt[i].epe), vt[i].efe, vt[i].ebrk);
      chk($sformatf("vec%0d idle", i), 32'({rx_valid_o, rx_busy_o}), 0);
    end
    send(5'b00011, 8'h1F, 1'b0, 2'b00);
    uart_rx_i = 1'b0;
    repeat (20 * OS) tick();
    chk("break busy low line", 32'(rx_busy_o), 1);
    expect_word("stop err", 8'h1F, 0, 1'b1, 1'b0);
    expect_word("break", 8'h00, -1, 1'b1, 1'b1);
    idle(3);
    chk("break released busy", 32'(rx_busy_o), 0);
    rx_ready_i = 1'b0;
    o0 = ovr_cnt;
    send(5'b11000, 8'h11, 1'b0, 2'b11);
    idle(4);
    chk("held valid", 32'(rx_valid_o), 1);
    chk("held data", 32'(rx_data_o), 32'h11);
    send(5'b11000, 8'h22, 1'b0, 2'b11);
    idle(4);
    chk("overrun keeps data", 32'(rx_data_o), 32'h11);
    chk("overrun pulses", 32'(ovr_cnt - o0), 1);
    rx_ready_i = 1'b1;
    @(posedge clk);
    #1 rx_ready_i = 1'b0;
    expect_word("overrun old", 8'h11, 0, 1'b0, 1'b0);
    chk("valid cleared", 32'(rx_valid_o), 0);
    send(5'b11000, 8'h11, 1'b0, 2'b11);
    idle(4);
    o0 = ovr_cnt;
    send(5'b11000, 8'h22, 1'b0, 2'b11, 10 * OS - 5);
    idle(4);
    chk("same-cycle data", 32'(rx_data_o), 32'h22);
    chk("same-cycle valid", 32'(rx_valid_o), 1);
    chk("same-cycle no overrun", 32'(ovr_cnt - o0), 0);
    expect_word("same-cycle old", 8'h11, 0, 1'b0, 1'b0);
    rx_ready_i = 1'b1;
    idle(2);
    expect_word("same-cycle new", 8'h22, 0, 1'b0, 1'b0);
    uart_rx_i = 1'b0;
    repeat (6) tick();
    chk("glitch busy", 32'(rx_busy_o), 1);
    idle(16);
    chk("glitch dropped", 32'({rx_valid_o, rx_busy_o}), 0);
    chk("glitch no word", 32'(q.size()), 0);
    send(5'b11000, 8'hA5, 1'b0, 2'b11, -1, 4 * OS + 9);
    idle(4);
    expect_word("vote", 8'hA5, 0, 1'b0, 1'b0);
    send(5'b11000, 8'hA5, 1'b0, 2'b11, -1, -1, 4 * OS + 2);
    rx_en_i = 1'b1;
    idle(8);
    chk("disable idle", 32'({rx_valid_o, rx_busy_o}), 0);
    chk("disable no word", 32'(q.size()), 0);
    rx_ready_i = 1'b0;
    send(5'b11000, 8'h11, 1'b0, 2'b11);
    idle(2);
    chk("pre-reset valid", 32'(rx_valid_o), 1);
    uart_rx_i = 1'b0;
    repeat (40) tick();
    chk("pre-reset busy", 32'(rx_busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async reset valid", 32'(rx_valid_o), 0);
    chk("async reset data", 32'(rx_data_o), 0);
    chk("async reset busy", 32'(rx_busy_o), 0);
    chk("async reset flags", 32'({rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o}), 0);
    #2 rst_ni = 1'b1;
    uart_rx_i = 1'b1;
    rx_ready_i = 1'b1;
    idle(4);
    send(5'b11000, 8'h5A, 1'b0, 2'b11);
    idle(4);
    expect_word("after reset", 8'h5A, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised successor UART receiver. Oversamples `uart_rx_i` at OVERSAMPLE ticks per bit, using `baud_en_i` as the tick strobe.
- Adds:
  - input synchroniser and 3-sample majority vote;
  - odd/even parity and 1/2 stop bits;
  - framing, overrun and break detection;
  - valid/ready output holding register.
- Sits between the pad and the UART RX FIFO / register bank.

Parameters:
- MAX_UART_DATA_W, 8, maximum data width; supported frame widths are 5..MAX_UART_DATA_W, and MAX_UART_DATA_W >= 8.
- OVERSAMPLE, 16, baud ticks per bit; even, >= 8.
- SAMPLE_COUNTER_WIDTH, $clog2(OVERSAMPLE), local, sample counter width.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- baud_en_i  in  1  one-clk strobe at OVERSAMPLE x baud rate.
- rx_en_i  in  1  receiver enable.
- uart_rx_i  in  1  asynchronous serial line, idle high.
- rx_conf_i  in  5  configuration:
  - [0] parity_en;
  - [1] parity_odd;
  - [2] two_stop;
  - [4:3] data width = 5 + value.
- rx_ready_i  in  1  consumer accepts the held word.
- rx_valid_o  out  1  held word valid.
- rx_data_o  out  MAX_UART_DATA_W  received data, LSB-aligned, upper bits 0.
- rx_parity_err_o  out  1  parity error for the held word.
- rx_frame_err_o  out  1  stop-bit error for the held word.
- rx_break_o  out  1  held word is a break.
- rx_overrun_o  out  1  one-clk pulse: a completed frame was dropped.
- rx_busy_o  out  1  frame in progress.

Behaviour:

Reset:
- Clock is `clk_i`; reset is asynchronous, active-low (`rst_ni`).
- On reset, all outputs are 0 and `rx_data_o` is 0.
- Synchroniser flops reset to 1. FSM resets to Idle.

Input path:
- 2-flop synchroniser, clocked every `clk_i`.
- Every other piece of logic advances only when `baud_en_i` = 1, except the output handshake and the overrun pulse, which act per `clk_i`.

Configuration:
- `rx_conf_i` is latched on start-edge detection and held for the whole frame.

FSM states: Idle, Start, Data, Parity, Stop, BreakWait.

Idle:
- `rx_en_i` = 1 and synchronised line = 0 -> Start.
- The sample counter is cleared to 0 on entry to Start.

Sample counter:
- Counts 0..OVERSAMPLE-1 per bit, then wraps to 0.
- Vote samples are taken at M-1, M and M+1, where M = OVERSAMPLE/2.
- The bit value is the majority of the three samples, resolved at count M+1.

Start:
- Vote = 1 -> glitch; return to Idle with no output.
- Vote = 0 -> continue; at count OVERSAMPLE-1 go to Data.

Data:
- Bits shift in LSB first.
- After the configured number of bits (5..8): Parity if parity_en, else Stop.

Parity:
- Check: XOR of data bits and parity bit must equal parity_odd; otherwise parity error.

Stop:
- Vote = 0 -> frame error.
- two_stop: both stop bits are checked; the error flag is the OR of both.
- The frame completes at count M+1 of the final stop bit. This allows back-to-back start detection.
- Next state is BreakWait if a break was detected, else Idle.

Break:
- Break = all data bits 0, parity bit 0 (if enabled) and final stop vote 0.
- A break also sets frame error.
- BreakWait waits until the synchronised line is 1, then goes to Idle.

Completion:
- On the `clk_i` edge of the completion tick, the data word and its flags are loaded into the holding register and `rx_valid_o` is set.
- Latency: `rx_valid_o` rises 1 clk after the completing baud tick, i.e. 2 sync clks plus 1 after the line edge seen at that tick.

Handshake and overrun:
- A word is accepted when `rx_valid_o` && `rx_ready_i`.
- On acceptance, `rx_valid_o` clears and the flags clear.
- Data is held stable while `rx_valid_o` = 1 and `rx_ready_i` = 0.
- Overrun: completion while `rx_valid_o` = 1 and no acceptance in the same cycle:
  - the new frame is discarded;
  - the old word is retained;
  - `rx_overrun_o` pulses for 1 clk.
- Completion and acceptance in the same cycle: the new word is loaded, `rx_valid_o` stays 1, and there is no overrun.

Busy:
- `rx_busy_o` = 1 in Start, Data, Parity, Stop and BreakWait; 0 in Idle.

Disable:
- `rx_en_i` deasserted mid-frame aborts the frame at the next baud tick.
- The FSM returns to Idle with no output and no flags; the holding register is untouched.

Reset mid-frame:
- Everything returns to reset values immediately and any held word is lost.

Test Plan:
1. 8N1 (conf 5'b11000), OVERSAMPLE 16, byte 0xA5 with `rx_ready_i` = 1 -> one `rx_valid_o` pulse, `rx_data_o` = 0xA5, all error flags 0.
2. 7E2 (conf 5'b10101), data 0x35 sent with parity bit 1 (wrong) -> `rx_data_o` = 0x35, `rx_parity_err_o` = 1, `rx_frame_err_o` = 0. The same frame with parity bit 0 -> no error.
3. 5O1 (conf 5'b00011), data 0x1F, stop bit driven 0 -> `rx_data_o` = 0x1F, `rx_frame_err_o` = 1; then line held 0 for 20 bit times -> `rx_break_o` = 1 with data 0, `rx_busy_o` = 1 until line high, then Idle.
4. Hold `rx_ready_i` = 0, send 0x11 then 0x22 -> `rx_data_o` stays 0x11 and `rx_overrun_o` pulses once. Second test: assert `rx_ready_i` in the exact completion cycle of 0x22 -> `rx_data_o` = 0x22, no overrun.
5. Noise: a 6-tick low glitch on idle line -> no frame, `rx_busy_o` returns to 0. A single-tick inverted sample at count M of a data bit -> majority vote gives the correct byte.
6. Deassert `rx_en_i` during data bit 3 -> no `rx_valid_o`, FSM in Idle. Pulse `rst_ni` low mid-frame -> all outputs 0 asynchronously, then 0x5A is received correctly.
